// File: rtl/serial_frame_rx_if.sv
// Output-side bundle of serial_frame_rx: serial line in, word handshake and status pulses out.
// The slave modport is the receiver; the master modport is whoever drives SIN and consumes words.
interface serial_frame_rx_if #(
  parameter int unsigned Width = 8
);
  logic             sin;
  logic [Width-1:0] dout;
  logic             dvalid;
  logic             dready;
  logic             busy;
  logic             ferr;
  logic             perr;
  logic             ovr;

  modport slave (
    input  sin,
    input  dready,
    output dout,
    output dvalid,
    output busy,
    output ferr,
    output perr,
    output ovr
  );

  modport master (
    output sin,
    output dready,
    input  dout,
    input  dvalid,
    input  busy,
    input  ferr,
    input  perr,
    input  ovr
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, Width data bits LSB first, optional even parity, stop bit.
// Even parity is compiled in when SERIAL_FRAME_RX_PARITY_EN is defined.
module serial_frame_rx #(
  parameter int unsigned Width = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  serial_frame_rx_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(Width);

  typedef enum logic [1:0] {StIdle, StData, StPar, StStop} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] shift_q;
  logic [Width-1:0] dout_q;
  logic             dvalid_q;
  logic             ferr_q;
  logic             perr_q;
  logic             ovr_q;
  logic             par_bad;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_q;
  assign par_bad = (^shift_q) != par_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (dvalid_q && bus_io.dready) begin
        dvalid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!bus_io.sin) begin
            state_q <= StData;
            cnt_q   <= '0;
          end
        end
        StData: begin
          shift_q <= {bus_io.sin, shift_q[Width-1:1]};
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(Width - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_q <= StPar;
`else
            state_q <= StStop;
`endif
          end
        end
        StPar: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          par_q <= bus_io.sin;
`endif
          state_q <= StStop;
        end
        StStop: begin
          // A low line here is a bad stop bit, never a new start bit.
          state_q <= StIdle;
          if (!bus_io.sin) begin
            ferr_q <= 1'b1;
          end else if (par_bad) begin
            perr_q <= 1'b1;
          end else if (dvalid_q && !bus_io.dready) begin
            ovr_q <= 1'b1;
          end else begin
            dout_q   <= shift_q;
            dvalid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.dout   = dout_q;
  assign bus_io.dvalid = dvalid_q;
  assign bus_io.busy   = (state_q != StIdle);
  assign bus_io.ferr   = ferr_q;
  assign bus_io.perr   = perr_q;
  assign bus_io.ovr    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with a frame-level model checked every cycle.
// Follows SERIAL_FRAME_RX_PARITY_EN so the same bench covers both builds.
module tb_serial_frame_rx;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_frame_rx_if #(.Width(W)) bus ();

  serial_frame_rx #(.Width(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: what the outputs must show after the most recent edge.
  logic [W-1:0] m_dout;
  logic         m_dvalid, m_busy, m_ferr, m_perr, m_ovr;
  logic         pre_dvalid, xfer;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_dvalid", 32'(bus.dvalid), 32'(m_dvalid));
      check("cyc_busy",   32'(bus.busy),   32'(m_busy));
      check("cyc_ferr",   32'(bus.ferr),   32'(m_ferr));
      check("cyc_perr",   32'(bus.perr),   32'(m_perr));
      check("cyc_ovr",    32'(bus.ovr),    32'(m_ovr));
      if (m_dvalid) check("cyc_dout", 32'(bus.dout), 32'(m_dout));
    end
  end

  task automatic tick(input logic s, input logic r);
    bus.sin    = s;
    bus.dready = r;
    @(posedge clk);
    #1;
    pre_dvalid = m_dvalid;
    xfer       = m_dvalid && r;
    if (xfer) m_dvalid = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) tick(1'b1, r);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.sin    = 1'b1;
    bus.dready = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_dout   = '0;
    m_dvalid = 1'b0;
    m_busy   = 1'b0;
    m_ferr   = 1'b0;
    m_perr   = 1'b0;
    m_ovr    = 1'b0;
  endtask

  // DREADY is held low through the frame except on the stop-bit edge.
  task automatic send_frame(input logic [W-1:0] d, input logic bad_par, input logic stopb,
                            input logic rdy_stop);
    tick(1'b0, 1'b0);
    m_busy = 1'b1;
    for (int i = 0; i < W; i++) tick(d[i], 1'b0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    tick((^d) ^ bad_par, 1'b0);
`endif
    tick(stopb, rdy_stop);
    m_busy = 1'b0;
    if (!stopb) m_ferr = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    else if (bad_par) m_perr = 1'b1;
`endif
    else if (pre_dvalid && !xfer) m_ovr = 1'b1;
    else begin
      m_dout   = d;
      m_dvalid = 1'b1;
    end
  endtask

  logic [W-1:0] tbl [5];
  logic [W-1:0] d5a;

  initial begin
    tbl[0] = 8'h00; tbl[1] = 8'hFF; tbl[2] = 8'h81; tbl[3] = 8'h7E; tbl[4] = 8'h12;
    bus.sin    = 1'b1;
    bus.dready = 1'b0;
    do_reset();
    chk_en = 1'b1;
    check("rst_dout",   32'(bus.dout),   32'h0);
    check("rst_dvalid", 32'(bus.dvalid), 32'h0);
    check("rst_busy",   32'(bus.busy),   32'h0);
    idle(2, 1'b0);

    // Good frame, consumer stalled, then accepted.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("good_dvalid", 32'(bus.dvalid), 32'h1);
    check("good_dout",   32'(bus.dout),   32'hA5);
    idle(3, 1'b0);
    check("good_hold",   32'(bus.dout),   32'hA5);
    tick(1'b1, 1'b1);
    check("good_taken",  32'(bus.dvalid), 32'h0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    check("perr_pulse",  32'(bus.perr),   32'h1);
    check("perr_noferr", 32'(bus.ferr),   32'h0);
    check("perr_nodv",   32'(bus.dvalid), 32'h0);
    tick(1'b1, 1'b0);
    check("perr_end",    32'(bus.perr),   32'h0);
`endif

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse",  32'(bus.ferr),   32'h1);
    check("ferr_noperr", 32'(bus.perr),   32'h0);
    check("ferr_nodv",   32'(bus.dvalid), 32'h0);
    idle(W + 4, 1'b0);
    check("ferr_idle",   32'(bus.busy),   32'h0);
    check("ferr_nofrm",  32'(bus.dvalid), 32'h0);

    // Back-to-back frames: overrun, then load on the same edge as a transfer.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    check("ovr_pulse", 32'(bus.ovr),  32'h1);
    check("ovr_dout",  32'(bus.dout), 32'h3C);
    tick(1'b1, 1'b1);
    check("ovr_end",   32'(bus.ovr),  32'h0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    check("swap_dout",   32'(bus.dout),   32'hC3);
    check("swap_dvalid", 32'(bus.dvalid), 32'h1);
    check("swap_noovr",  32'(bus.ovr),    32'h0);
    tick(1'b1, 1'b1);

    // Reset during data bit 4 with a word still pending.
    send_frame(8'h96, 1'b0, 1'b1, 1'b0);
    d5a = 8'h5A;
    tick(1'b0, 1'b0);
    m_busy = 1'b1;
    for (int i = 0; i < 4; i++) tick(d5a[i], 1'b0);
    do_reset();
    check("mrst_busy",   32'(bus.busy),   32'h0);
    check("mrst_dvalid", 32'(bus.dvalid), 32'h0);
    idle(1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check("mrst_dout",   32'(bus.dout),   32'h5A);
    tick(1'b1, 1'b1);

    for (int k = 0; k < 5; k++) begin
      send_frame(tbl[k], 1'b0, 1'b1, 1'b0);
      check("tbl_dout", 32'(bus.dout), 32'(tbl[k]));
      tick(1'b1, 1'b1);
    end
    idle(2, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
